mdu: RTL

- Multi-cycle multiply/divide unit for the MIPS datapath, sitting in the EX stage beside the single-cycle ALU.
- Executes MULT, MULTU, DIV and DIVU with fixed latencies, and supports MTHI and MTLO writes.
- Owns the architectural HI/LO registers.
- Raises busy so the hazard unit stalls any later MD-class instruction.

---
 rtl/mdu.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed at issue into a holding register and retired after a fixed latency.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  operation,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } mdu_op_e;

    typedef enum logic {IDLE, RUN} state_e;

    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    res_t        res_q, res_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] dvs_u, a_mag, b_mag, b_mag_nz;
    logic [31:0] quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;
    logic        div0;

    assign prod_s = {{32{operand1[31]}}, operand1} * {{32{operand2[31]}}, operand2};
    assign prod_u = {32'd0, operand1} * {32'd0, operand2};

    // Signed divide goes through magnitudes so 0x80000000 / -1 needs no special case.
    assign div0     = (operand2 == 32'd0);
    assign dvs_u    = div0 ? 32'd1 : operand2;
    assign a_mag    = operand1[31] ? (~operand1 + 32'd1) : operand1;
    assign b_mag    = operand2[31] ? (~operand2 + 32'd1) : operand2;
    assign b_mag_nz = div0 ? 32'd1 : b_mag;
    assign quo_u    = operand1 / dvs_u;
    assign rem_u    = operand1 % dvs_u;
    assign quo_m    = a_mag / b_mag_nz;
    assign rem_m    = a_mag % b_mag_nz;
    assign quo_s    = (operand1[31] ^ operand2[31]) ? (~quo_m + 32'd1) : quo_m;
    assign rem_s    = operand1[31] ? (~rem_m + 32'd1) : rem_m;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            res_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (operation)
                        OP_MULT: begin
                            res_d   = {1'b1, prod_s};
                            cnt_d   = MUL_N;
                            state_d = RUN;
                        end
                        OP_MULTU: begin
                            res_d   = {1'b1, prod_u};
                            cnt_d   = MUL_N;
                            state_d = RUN;
                        end
                        OP_DIV: begin
                            res_d   = {~div0, rem_s, quo_s};
                            cnt_d   = DIV_N;
                            state_d = RUN;
                        end
                        OP_DIVU: begin
                            res_d   = {~div0, rem_u, quo_u};
                            cnt_d   = DIV_N;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = operand1;
                        OP_MTLO: lo_d = operand1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (res_q.wr) begin
                        hi_d = res_q.hi;
                        lo_d = res_q.lo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
